// File: rtl/lock_array_pkg.sv
// rtl/lock_array_pkg.sv - shared lock state type and sizing helpers for the lock array
package lock_array_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPENED  = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } lock_state_t;

  // Timer must hold the larger of the two reload values plus headroom for the count itself.
  function automatic int timer_width(input int travel, input int dwell);
    int biggest;
    biggest = (travel > dwell) ? travel : dwell;
    return (biggest < 1) ? 1 : $clog2(biggest + 1);
  endfunction

  function automatic int retry_width(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/lock_array_channel.sv
// rtl/lock_array_channel.sv - one lock FSM with its travel/dwell timer and obstruction retry counter
module lock_channel
  import lock_array_pkg::*;
#(
  parameter int TRAVEL_CYCLES     = 8,
  parameter int AUTO_CLOSE_CYCLES = 64,
  parameter int MAX_RETRIES       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        open,
  input  logic        close,
  input  logic        obstruct,
  input  logic        clear_fault,
  input  logic        lock_all,
  output lock_state_t state,
  output logic        opened,
  output logic        closed,
  output logic        fault
);

  localparam int TIMER_W = timer_width(TRAVEL_CYCLES, AUTO_CLOSE_CYCLES);
  localparam int RETRY_W = retry_width(MAX_RETRIES);

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  // With auto-close disabled the dwell timer is never consulted, so park it at zero.
  localparam logic [TIMER_W-1:0] DWELL_LOAD =
    (AUTO_CLOSE_CYCLES == 0) ? '0 : TIMER_W'(AUTO_CLOSE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
  localparam logic               AUTO_EN    = (AUTO_CLOSE_CYCLES != 0);

  lock_state_t        state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [RETRY_W-1:0] retry_q;
  logic               timer_zero;

  assign timer_zero = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLOSED;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      case (state_q)
        CLOSED: begin
          if (open && !lock_all) begin
            state_q <= OPENING;
            timer_q <= TRAVEL_LOAD;
          end
        end

        OPENING: begin
          if (timer_zero) begin
            state_q <= OPENED;
            timer_q <= DWELL_LOAD;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        OPENED: begin
          if (close || lock_all) begin
            state_q <= CLOSING;
            timer_q <= TRAVEL_LOAD;
          end else if (open) begin
            timer_q <= DWELL_LOAD;
          end else if (AUTO_EN && timer_zero) begin
            state_q <= CLOSING;
            timer_q <= TRAVEL_LOAD;
          end else if (AUTO_EN) begin
            timer_q <= timer_q - 1'b1;
          end
        end

        CLOSING: begin
          // An obstruction on the completing cycle still wins over reaching CLOSED.
          if (obstruct) begin
            if (retry_q == RETRY_LAST) begin
              state_q <= FAULT;
            end else begin
              state_q <= OPENING;
              retry_q <= retry_q + 1'b1;
              timer_q <= TRAVEL_LOAD;
            end
          end else if (timer_zero) begin
            state_q <= CLOSED;
            retry_q <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        FAULT: begin
          if (clear_fault) begin
            state_q <= OPENED;
            retry_q <= '0;
            timer_q <= DWELL_LOAD;
          end
        end

        default: begin
          state_q <= CLOSED;
          timer_q <= '0;
          retry_q <= '0;
        end
      endcase
    end
  end

  assign state  = state_q;
  assign opened = (state_q == OPENED);
  assign closed = (state_q == CLOSED);
  assign fault  = (state_q == FAULT);

endmodule

// File: rtl/lock_array.sv
// rtl/lock_array.sv - bank of independent lock channels sharing only the global lock command
module lock_array
  import lock_array_pkg::*;
#(
  parameter int N_LOCKS           = 4,
  parameter int TRAVEL_CYCLES     = 8,
  parameter int AUTO_CLOSE_CYCLES = 64,
  parameter int MAX_RETRIES       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic        [N_LOCKS-1:0] open,
  input  logic        [N_LOCKS-1:0] close,
  input  logic        [N_LOCKS-1:0] obstruct,
  input  logic        [N_LOCKS-1:0] clear_fault,
  input  logic                      lock_all,
  output lock_state_t [N_LOCKS-1:0] state,
  output logic        [N_LOCKS-1:0] opened,
  output logic        [N_LOCKS-1:0] closed,
  output logic                      any_fault
);

  logic [N_LOCKS-1:0] fault;

  for (genvar g = 0; g < N_LOCKS; g++) begin : g_ch
    lock_channel #(
      .TRAVEL_CYCLES    (TRAVEL_CYCLES),
      .AUTO_CLOSE_CYCLES(AUTO_CLOSE_CYCLES),
      .MAX_RETRIES      (MAX_RETRIES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .open       (open[g]),
      .close      (close[g]),
      .obstruct   (obstruct[g]),
      .clear_fault(clear_fault[g]),
      .lock_all   (lock_all),
      .state      (state[g]),
      .opened     (opened[g]),
      .closed     (closed[g]),
      .fault      (fault[g])
    );
  end

  assign any_fault = |fault;

endmodule

// File: tb/tb_lock_array.sv
// tb/tb_lock_array.sv - scenario and randomized checks of lock_array against an elapsed-time model
module tb_lock_array;
  import lock_array_pkg::*;

  localparam int N  = 4;
  localparam int TC = 4;
  localparam int AC = 10;
  localparam int MR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      open, close, obstruct, clear_fault;
  logic              lock_all;
  lock_state_t [N-1:0] state;
  logic [N-1:0]      opened, closed;
  logic              any_fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: state, cycles already spent in the current travel/dwell, obstructions since last close.
  lock_state_t m_state [N];
  int          m_el    [N];
  int          m_ob    [N];

  lock_array #(
    .N_LOCKS(N), .TRAVEL_CYCLES(TC), .AUTO_CLOSE_CYCLES(AC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst(rst), .open(open), .close(close), .obstruct(obstruct),
    .clear_fault(clear_fault), .lock_all(lock_all), .state(state),
    .opened(opened), .closed(closed), .any_fault(any_fault)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_state[c] = CLOSED; m_el[c] = 0; m_ob[c] = 0;
      end else begin
        case (m_state[c])
          CLOSED:  if (open[c] && !lock_all) begin m_state[c] = OPENING; m_el[c] = 0; end
          OPENING: if (m_el[c] == TC - 1) begin m_state[c] = OPENED; m_el[c] = 0; end
                   else m_el[c]++;
          OPENED:  if (close[c] || lock_all) begin m_state[c] = CLOSING; m_el[c] = 0; end
                   else if (open[c]) m_el[c] = 0;
                   else if (m_el[c] == AC - 1) begin m_state[c] = CLOSING; m_el[c] = 0; end
                   else m_el[c]++;
          CLOSING: if (obstruct[c]) begin
                     m_ob[c]++;
                     if (m_ob[c] == MR) m_state[c] = FAULT;
                     else begin m_state[c] = OPENING; m_el[c] = 0; end
                   end else if (m_el[c] == TC - 1) begin m_state[c] = CLOSED; m_ob[c] = 0; end
                   else m_el[c]++;
          default: if (clear_fault[c]) begin m_state[c] = OPENED; m_el[c] = 0; m_ob[c] = 0; end
        endcase
      end
    end
  endtask

  task automatic clear_inputs();
    open = '0; close = '0; obstruct = '0; clear_fault = '0; lock_all = 1'b0; rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < N; c++) begin
      n_checks++;
      if (state[c] !== CLOSED) begin
        n_fail++; $display("FAIL reset_state[%0d]: got %0d expected %0d", c, state[c], CLOSED);
      end
    end
    n_checks++;
    if (closed !== 4'b1111 || opened !== 4'b0000 || any_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: closed=%b opened=%b any_fault=%b expected 1111 0000 0", closed, opened, any_fault);
    end
  endtask

  task automatic test_open_travel();
    open[0] = 1'b1;
    tick();
    open[0] = 1'b0;
    for (int i = 0; i < TC; i++) begin
      n_checks++;
      if (state[0] !== OPENING) begin
        n_fail++; $display("FAIL travel_opening[%0d]: got %0d expected %0d", i, state[0], OPENING);
      end
      tick();
    end
    n_checks++;
    if (state[0] !== OPENED || opened !== 4'b0001) begin
      n_fail++; $display("FAIL travel_opened: state=%0d opened=%b expected %0d 0001", state[0], opened, OPENED);
    end
    n_checks++;
    if (state[1] !== CLOSED || state[2] !== CLOSED || state[3] !== CLOSED) begin
      n_fail++; $display("FAIL travel_others: got %0d %0d %0d expected all %0d", state[1], state[2], state[3], CLOSED);
    end
  endtask

  task automatic test_auto_close();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); cnt++;
      if (state[0] === CLOSING) break;
    end
    n_checks++;
    if (cnt !== AC || state[0] !== CLOSING) begin
      n_fail++; $display("FAIL auto_close_delay: got %0d cycles state %0d expected %0d cycles", cnt, state[0], AC);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); cnt++;
      if (state[0] === CLOSED) break;
    end
    n_checks++;
    if (cnt !== TC || state[0] !== CLOSED) begin
      n_fail++; $display("FAIL auto_close_travel: got %0d cycles state %0d expected %0d cycles", cnt, state[0], TC);
    end
    open[0] = 1'b1; tick(); open[0] = 1'b0;
    repeat (TC) tick();
    for (int i = 0; i < 30; i++) begin
      open[0] = (i % 5 == 0);
      tick();
      n_checks++;
      if (state[0] !== OPENED) begin
        n_fail++; $display("FAIL keepalive[%0d]: got %0d expected %0d", i, state[0], OPENED);
      end
    end
    open[0] = 1'b0;
  endtask

  task automatic test_obstruct_fault();
    close[0] = 1'b1; tick(); close[0] = 1'b0;
    obstruct[0] = 1'b1; tick(); obstruct[0] = 1'b0;
    n_checks++;
    if (state[0] !== OPENING) begin
      n_fail++; $display("FAIL obstruct_reverse: got %0d expected %0d", state[0], OPENING);
    end
    repeat (TC) tick();
    n_checks++;
    if (state[0] !== OPENED) begin
      n_fail++; $display("FAIL obstruct_reopened: got %0d expected %0d", state[0], OPENED);
    end
    close[0] = 1'b1; tick(); close[0] = 1'b0;
    obstruct[0] = 1'b1; tick(); obstruct[0] = 1'b0;
    n_checks++;
    if (state[0] !== FAULT || any_fault !== 1'b1) begin
      n_fail++; $display("FAIL fault_entry: state=%0d any_fault=%b expected %0d 1", state[0], any_fault, FAULT);
    end
    open[0] = 1'b1; close[0] = 1'b1; lock_all = 1'b1; tick();
    open[0] = 1'b0; close[0] = 1'b0; lock_all = 1'b0;
    n_checks++;
    if (state[0] !== FAULT) begin
      n_fail++; $display("FAIL fault_hold: got %0d expected %0d", state[0], FAULT);
    end
    clear_fault[0] = 1'b1; tick(); clear_fault[0] = 1'b0;
    n_checks++;
    if (state[0] !== OPENED || any_fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_clear: state=%0d any_fault=%b expected %0d 0", state[0], any_fault, OPENED);
    end
  endtask

  task automatic test_lock_all();
    open[2] = 1'b1; tick(); open[2] = 1'b0;
    lock_all = 1'b1; open[1] = 1'b1; tick();
    lock_all = 1'b0; open[1] = 1'b0;
    n_checks++;
    if (state[0] !== CLOSING || state[1] !== CLOSED || state[2] !== OPENING) begin
      n_fail++;
      $display("FAIL lock_all: got %0d %0d %0d expected %0d %0d %0d", state[0], state[1], state[2], CLOSING, CLOSED, OPENING);
    end
    tick(); tick();
    n_checks++;
    if (state[2] !== OPENING) begin
      n_fail++; $display("FAIL lock_all_ch2_travel: got %0d expected %0d", state[2], OPENING);
    end
    tick();
    n_checks++;
    if (state[2] !== OPENED) begin
      n_fail++; $display("FAIL lock_all_ch2_done: got %0d expected %0d", state[2], OPENED);
    end
  endtask

  task automatic test_close_priority();
    for (int i = 0; i < 20 && state[0] !== CLOSED; i++) tick();
    open[0] = 1'b1; tick(); open[0] = 1'b0;
    repeat (TC) tick();
    open[0] = 1'b1; close[0] = 1'b1; tick();
    open[0] = 1'b0; close[0] = 1'b0;
    n_checks++;
    if (state[0] !== CLOSING) begin
      n_fail++; $display("FAIL close_beats_open: got %0d expected %0d", state[0], CLOSING);
    end
    repeat (TC - 1) tick();
    n_checks++;
    if (state[0] !== CLOSING) begin
      n_fail++; $display("FAIL closing_last_cycle: got %0d expected %0d", state[0], CLOSING);
    end
    obstruct[0] = 1'b1; tick(); obstruct[0] = 1'b0;
    n_checks++;
    if (state[0] !== OPENING) begin
      n_fail++; $display("FAIL obstruct_at_completion: got %0d expected %0d", state[0], OPENING);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    open[1] = 1'b1; tick(); open[1] = 1'b0;
    repeat (TC) tick();
    for (int r = 0; r < MR; r++) begin
      close[1] = 1'b1; tick(); close[1] = 1'b0;
      obstruct[1] = 1'b1; tick(); obstruct[1] = 1'b0;
      if (r < MR - 1) repeat (TC) tick();
    end
    open[0] = 1'b1; tick(); open[0] = 1'b0;
    tick();
    n_checks++;
    if (state[1] !== FAULT || state[0] !== OPENING) begin
      n_fail++; $display("FAIL pre_reset: ch0=%0d ch1=%0d expected %0d %0d", state[0], state[1], OPENING, FAULT);
    end
    rst = 1'b1; open = 4'hF; clear_fault = 4'hF; tick();
    clear_inputs();
    n_checks++;
    if (state !== {N{CLOSED}} || closed !== 4'b1111 || any_fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_midway: closed=%b any_fault=%b expected 1111 0", closed, any_fault);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_opened, exp_closed;
    logic         exp_fault;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) begin
        open[c]        = ($urandom_range(99) < 20);
        close[c]       = ($urandom_range(99) < 12);
        obstruct[c]    = ($urandom_range(99) < 15);
        clear_fault[c] = ($urandom_range(99) < 10);
      end
      lock_all = ($urandom_range(99) < 4);
      rst      = ($urandom_range(999) < 5);
      tick();
      exp_fault = 1'b0;
      for (int c = 0; c < N; c++) begin
        exp_opened[c] = (m_state[c] == OPENED);
        exp_closed[c] = (m_state[c] == CLOSED);
        if (m_state[c] == FAULT) exp_fault = 1'b1;
        n_checks++;
        if (state[c] !== m_state[c]) begin
          n_fail++; $display("FAIL random_state[%0d] cycle %0d: got %0d expected %0d", c, i, state[c], m_state[c]);
        end
      end
      n_checks++;
      if (opened !== exp_opened || closed !== exp_closed || any_fault !== exp_fault) begin
        n_fail++;
        $display("FAIL random_flags cycle %0d: opened=%b closed=%b fault=%b expected %b %b %b",
                 i, opened, closed, any_fault, exp_opened, exp_closed, exp_fault);
      end
    end
    clear_inputs();
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin m_state[c] = CLOSED; m_el[c] = 0; m_ob[c] = 0; end
    clear_inputs();
    test_reset();
    test_open_travel();
    test_auto_close();
    test_obstruct_fault();
    test_lock_all();
    test_close_priority();
    test_reset_midway();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
